// File: rtl/cordic_arbiter.sv
// cordic_arbiter: shares one pipelined CORDIC rotator among N_REQ requesters.
// Each issued angle carries a requester tag down a shift register matched to
// the rotator latency, so every rotated (x,y) pair returns to its owner.
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   issue_en          0 = grant nothing this cycle (pipeline keeps draining)
//   req_valid/angle   per-requester angle offer; requester i at [i*W +: W]
//   req_ready         one-hot grant
//   cordic_z          registered angle to the rotator
//   cordic_x/y        rotator outputs
//   resp_valid        one-hot, one-cycle result pulse
//   resp_x/y          registered rotated result (holds between pulses)
//   busy              any tag in flight or any resp_valid high
// Build option: CORDIC_ARB_PRIO_EN gives requester 0 strict priority;
// requesters 1..N_REQ-1 then round-robin among themselves.
module cordic_arbiter #(
  parameter int N_REQ      = 4,
  parameter int W          = 11,
  parameter int CORDIC_LAT = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               issue_en,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_angle,
  output logic [N_REQ-1:0]   req_ready,
  output logic [W-1:0]       cordic_z,
  input  logic [W-1:0]       cordic_x,
  input  logic [W-1:0]       cordic_y,
  output logic [N_REQ-1:0]   resp_valid,
  output logic [W-1:0]       resp_x,
  output logic [W-1:0]       resp_y,
  output logic               busy
);

  localparam int IW = $clog2(N_REQ);

  // registered state
  logic [IW-1:0]                 rr_ptr_q, rr_ptr_d;
  logic [W-1:0]                  cordic_z_q, cordic_z_d;
  logic [CORDIC_LAT-1:0]         tag_vld_q, tag_vld_d;
  logic [CORDIC_LAT-1:0][IW-1:0] tag_id_q, tag_id_d;
  logic [N_REQ-1:0]              resp_valid_q, resp_valid_d;
  logic [W-1:0]                  resp_x_q, resp_x_d;
  logic [W-1:0]                  resp_y_q, resp_y_d;

  // grant decode
  logic [N_REQ-1:0] rr_mask;
  logic             gnt_vld;
  logic [IW-1:0]    gnt_idx;
  int               cand;

  logic [W-1:0] ang [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ang
    assign ang[gi] = req_angle[gi*W +: W];
  end

  // Round-robin search starts one past the last granted requester.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    rr_mask = req_valid;
`ifdef CORDIC_ARB_PRIO_EN
    rr_mask[0] = 1'b0;
`endif
    for (int k = 1; k <= N_REQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      if (!gnt_vld && rr_mask[IW'(cand)]) begin
        gnt_vld = 1'b1;
        gnt_idx = IW'(cand);
      end
    end
`ifdef CORDIC_ARB_PRIO_EN
    if (req_valid[0]) begin
      gnt_vld = 1'b1;
      gnt_idx = '0;
    end
`endif
    if (!issue_en || rst) begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
    end
    req_ready = '0;
    if (gnt_vld) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  // issue, tag shift and response capture
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    cordic_z_d   = '0;
    tag_vld_d    = '0;
    tag_id_d     = '0;
    resp_valid_d = '0;
    resp_x_d     = resp_x_q;
    resp_y_d     = resp_y_q;

    if (gnt_vld) begin
      cordic_z_d = ang[gnt_idx];
`ifdef CORDIC_ARB_PRIO_EN
      if (gnt_idx != '0) begin
        rr_ptr_d = gnt_idx;
      end
`else
      rr_ptr_d = gnt_idx;
`endif
    end

    // The rotator never stalls, so neither does the tag pipe.
    tag_vld_d[0] = gnt_vld;
    tag_id_d[0]  = gnt_idx;
    for (int s = 1; s < CORDIC_LAT; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_id_d[s]  = tag_id_q[s-1];
    end

    // Rotator data is only trusted when its tag is valid.
    if (tag_vld_q[CORDIC_LAT-1]) begin
      resp_valid_d[tag_id_q[CORDIC_LAT-1]] = 1'b1;
      resp_x_d = cordic_x;
      resp_y_d = cordic_y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q     <= IW'(N_REQ - 1);
      cordic_z_q   <= '0;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
      resp_valid_q <= '0;
      resp_x_q     <= '0;
      resp_y_q     <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      cordic_z_q   <= cordic_z_d;
      tag_vld_q    <= tag_vld_d;
      tag_id_q     <= tag_id_d;
      resp_valid_q <= resp_valid_d;
      resp_x_q     <= resp_x_d;
      resp_y_q     <= resp_y_d;
    end
  end

  assign cordic_z   = cordic_z_q;
  assign resp_valid = resp_valid_q;
  assign resp_x     = resp_x_q;
  assign resp_y     = resp_y_q;
  assign busy       = (|tag_vld_q) | (|resp_valid_q);

endmodule

// File: tb/tb_cordic_arbiter.sv
// Testbench for cordic_arbiter: stand-in rotator plus a grant/response
// scoreboard model driven by directed and randomized stimulus.
module tb_cordic_arbiter;

  localparam int N        = 4;
  localparam int W        = 11;
  localparam int LAT      = 11;
  localparam int RESP_LAT = LAT + 1;
`ifdef CORDIC_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           issue_en = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_angle = '0;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   cordic_z;
  logic [W-1:0]   cordic_x;
  logic [W-1:0]   cordic_y;
  logic [N-1:0]   resp_valid;
  logic [W-1:0]   resp_x;
  logic [W-1:0]   resp_y;
  logic           busy;

  cordic_arbiter #(.N_REQ(N), .W(W), .CORDIC_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .issue_en(issue_en),
    .req_valid(req_valid), .req_angle(req_angle),
    .req_ready(req_ready), .cordic_z(cordic_z),
    .cordic_x(cordic_x), .cordic_y(cordic_y),
    .resp_valid(resp_valid), .resp_x(resp_x),
    .resp_y(resp_y), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in rotator: result for a z sampled by the arbiter at edge T
  // is presented so that the arbiter captures it at edge T+LAT.
  function automatic logic [W-1:0] fx(input logic [W-1:0] a);
    return a ^ 11'h2A5;
  endfunction
  function automatic logic [W-1:0] fy(input logic [W-1:0] a);
    return -a;
  endfunction

  logic [W-1:0] rot_pipe [LAT-1];
  always @(posedge clk) begin
    rot_pipe[0] <= cordic_z;
    for (int i = 1; i < LAT - 1; i++) rot_pipe[i] <= rot_pipe[i-1];
  end
  assign cordic_x = fx(rot_pipe[LAT-2]);
  assign cordic_y = fy(rot_pipe[LAT-2]);

  // Reference model
  typedef struct {
    int           id;
    logic [W-1:0] ang;
    int           due;
  } exp_t;

  exp_t         exp_q[$];
  int           model_ptr = N - 1;
  int           cyc_n = 0;
  int           checks = 0;
  int           errors = 0;
  int           resp_seen = 0;
  int           acc_n = 0;
  logic [W-1:0] last_x = '0;
  logic [W-1:0] last_y = '0;
  logic [W-1:0] exp_z = '0;

  function automatic int model_grant(input logic [N-1:0] v, input logic en);
    if (!en) return -1;
    if (PRIO && v[0]) return 0;
    for (int k = 1; k <= N; k++) begin
      automatic int i = (model_ptr + k) % N;
      if (!(PRIO && i == 0) && v[i]) return i;
    end
    return -1;
  endfunction

  // One clock cycle: compare DUT against the model, then advance.
  task automatic tick();
    int           g;
    logic [N-1:0] oh;
    exp_t         e;
    logic         rst_now;
    #2;
    checks++;
    if (busy !== (exp_q.size() != 0)) begin
      errors++;
      $display("FAIL busy cyc=%0d got=%b exp=%b", cyc_n, busy, exp_q.size() != 0);
    end
    if (exp_q.size() != 0 && exp_q[0].due == cyc_n) begin
      e = exp_q.pop_front();
      oh = '0;
      oh[e.id] = 1'b1;
      checks++;
      if (resp_valid !== oh) begin
        errors++;
        $display("FAIL resp_valid cyc=%0d got=%b exp=%b", cyc_n, resp_valid, oh);
      end
      checks++;
      if (resp_x !== fx(e.ang) || resp_y !== fy(e.ang)) begin
        errors++;
        $display("FAIL resp_xy cyc=%0d got=%h/%h exp=%h/%h",
                 cyc_n, resp_x, resp_y, fx(e.ang), fy(e.ang));
      end
      last_x = fx(e.ang);
      last_y = fy(e.ang);
    end else begin
      checks++;
      if (resp_valid !== '0) begin
        errors++;
        $display("FAIL resp_idle cyc=%0d got=%b exp=0000", cyc_n, resp_valid);
      end
      checks++;
      if (resp_x !== last_x || resp_y !== last_y) begin
        errors++;
        $display("FAIL resp_hold cyc=%0d got=%h/%h exp=%h/%h",
                 cyc_n, resp_x, resp_y, last_x, last_y);
      end
    end
    if (resp_valid != '0) resp_seen++;
    checks++;
    if (cordic_z !== exp_z) begin
      errors++;
      $display("FAIL cordic_z cyc=%0d got=%h exp=%h", cyc_n, cordic_z, exp_z);
    end
    g = rst ? -1 : model_grant(req_valid, issue_en);
    oh = '0;
    if (g >= 0) oh[g] = 1'b1;
    checks++;
    if (req_ready !== oh) begin
      errors++;
      $display("FAIL grant cyc=%0d got=%b exp=%b", cyc_n, req_ready, oh);
    end
    exp_z = '0;
    if (g >= 0) begin
      e.id  = g;
      e.ang = req_angle[g*W +: W];
      e.due = cyc_n + RESP_LAT;
      exp_q.push_back(e);
      exp_z = e.ang;
      acc_n++;
      if (!(PRIO && g == 0)) model_ptr = g;
    end
    rst_now = rst;
    @(posedge clk);
    #1;
    cyc_n++;
    if (rst_now) begin
      exp_q.delete();
      model_ptr = N - 1;
      last_x = '0;
      last_y = '0;
      exp_z = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic rand_angles();
    for (int i = 0; i < N; i++) req_angle[i*W +: W] = W'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    issue_en = 1'b1;
    req_valid = 4'b1111;
    rand_angles();
    @(posedge clk);
    #1;
    checks++;
    if (cordic_z !== '0 || resp_x !== '0 || resp_y !== '0) begin
      errors++;
      $display("FAIL reset_data got z=%h x=%h y=%h exp=0", cordic_z, resp_x, resp_y);
    end
    checks++;
    if (resp_valid !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got rv=%b busy=%b exp=0", resp_valid, busy);
    end
    checks++;
    if (req_ready !== '0) begin
      errors++;
      $display("FAIL reset_ready got=%b exp=0000", req_ready);
    end
    tick();
    rst = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_single();
    int  g_cyc;
    int  seen;
    bit  found;
    issue_en = 1'b1;
    req_valid = 4'b0001;
    req_angle = '0;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_ready got=%b exp=0001", req_ready);
    end
    g_cyc = cyc_n;
    tick();
    req_valid = '0;
    found = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      #1;
      if (resp_valid != '0) begin
        found = 1'b1;
        seen = cyc_n;
        checks++;
        if (resp_valid !== 4'b0001 || resp_x !== 11'h2A5 || resp_y !== 11'h000) begin
          errors++;
          $display("FAIL single_resp got=%b %h/%h exp=0001 2a5/000",
                   resp_valid, resp_x, resp_y);
        end
      end
      tick();
    end
    checks++;
    if (!found || seen - g_cyc != RESP_LAT) begin
      errors++;
      $display("FAIL single_latency got=%0d exp=%0d", found ? seen - g_cyc : -1, RESP_LAT);
    end
  endtask

  task automatic test_all_valid();
    logic [N-1:0] oh;
`ifdef CORDIC_ARB_PRIO_EN
    int seq[$] = '{0, 0, 0, 1, 2, 3};
`else
    int seq[$] = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    do_reset();
    issue_en = 1'b1;
    foreach (seq[i]) begin
`ifdef CORDIC_ARB_PRIO_EN
      req_valid = (i < 3) ? 4'b1111 : 4'b1110;
`else
      req_valid = 4'b1111;
`endif
      rand_angles();
      #1;
      oh = '0;
      oh[seq[i]] = 1'b1;
      checks++;
      if (req_ready !== oh) begin
        errors++;
        $display("FAIL order step=%0d got=%b exp=%b", i, req_ready, oh);
      end
      tick();
    end
    req_valid = '0;
    for (int k = 0; k < RESP_LAT + 2; k++) tick();
  endtask

  task automatic test_issue_off();
    do_reset();
    issue_en = 1'b1;
    req_valid = 4'b0110;
    rand_angles();
    tick();
    tick();
    issue_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rand_angles();
      #1;
      checks++;
      if (req_ready !== '0) begin
        errors++;
        $display("FAIL off_ready step=%0d got=%b exp=0000", k, req_ready);
      end
      tick();
    end
    checks++;
    if (cordic_z !== '0) begin
      errors++;
      $display("FAIL off_z got=%h exp=000", cordic_z);
    end
    req_valid = '0;
    for (int k = 0; k < 30 && exp_q.size() != 0; k++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL off_drain timeout got=%0d pending exp=0", exp_q.size());
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL off_busy got=%b exp=0", busy);
    end
    tick();
    issue_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int base;
    do_reset();
    issue_en = 1'b1;
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      rand_angles();
      tick();
    end
    req_valid = '0;
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    base = resp_seen;
    for (int k = 0; k < RESP_LAT + 4; k++) tick();
    checks++;
    if (resp_seen != base) begin
      errors++;
      $display("FAIL mid_reset_resp got=%0d pulses exp=0", resp_seen - base);
    end
    req_valid = 4'b1111;
    rand_angles();
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL mid_reset_first got=%b exp=0001", req_ready);
    end
    tick();
    req_valid = '0;
    for (int k = 0; k < RESP_LAT + 2; k++) tick();
  endtask

  task automatic test_random();
    int acc0;
    int seen0;
    do_reset();
    acc0 = acc_n;
    seen0 = resp_seen;
    for (int k = 0; k < 2000; k++) begin
      req_valid = N'($urandom_range(0, 15));
      issue_en = ($urandom_range(0, 9) != 0);
      rand_angles();
      tick();
    end
    req_valid = '0;
    issue_en = 1'b1;
    for (int k = 0; k < RESP_LAT + 4; k++) tick();
    checks++;
    if (resp_seen - seen0 != acc_n - acc0) begin
      errors++;
      $display("FAIL random_count got=%0d exp=%0d",
               resp_seen - seen0, acc_n - acc0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_valid();
    test_issue_off();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
